// File: rtl/gnrl_ram_pd_initiator.sv
// gnrl_ram_pd_initiator
// Initiator for a pseudo-dual-port RAM. It owns the RAM write port (posted,
// byte-masked writes) and the read port (1-cycle synchronous read). It
// exposes valid/ready read and write channels to a core/LSU.
//
// Read data is queued in a response FIFO. Credits count FIFO entries plus the
// in-flight read, so the FIFO can never overflow. Popping a response frees its
// credit one cycle later, which keeps rsp_ready_i off the rd_ready_o path.
//
// Same-cycle, same-word read/write hazard handling:
//   GNRL_RAM_PD_FWD_EN defined   : the read is accepted. The write data and mask
//                                  are registered and merged into the RAM read
//                                  data when it is captured.
//   GNRL_RAM_PD_FWD_EN undefined : the read is stalled for that cycle and
//                                  retried after the write has landed.
module gnrl_ram_pd_initiator #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // write channel
  input  logic                    wr_valid_i,
  output logic                    wr_ready_o,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_mask_i,
  // read request channel
  input  logic                    rd_valid_i,
  output logic                    rd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  // read response channel
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  // RAM write port
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_we_mask_o,
  output logic [ADDR_WIDTH-1:0]   ram_waddr_o,
  output logic [DATA_WIDTH-1:0]   ram_data_o,
  // RAM read port
  output logic [ADDR_WIDTH-1:0]   ram_raddr_o,
  input  logic [DATA_WIDTH-1:0]   ram_data_i
);

  localparam int OFS = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int MW  = DATA_WIDTH / 8;
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(RSP_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  wr_ready_r;     // doubles as "out of reset" flag
  logic                  inflight_r;     // a read was accepted last cycle
  logic [PW-1:0]         wptr_r;
  logic [PW-1:0]         rptr_r;
  logic [CW-1:0]         count_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] fifo_mem_r [RSP_DEPTH];

  logic                  word_match_s;
  logic                  stall_s;
  logic [CW:0]           occ_s;
  logic                  rd_ready_s;
  logic                  rd_fire_s;
  logic                  wr_fire_s;
  logic                  push_s;
  logic                  pop_s;
  logic [CW-1:0]         count_nxt_s;
  logic [DATA_WIDTH-1:0] capture_s;

`ifdef GNRL_RAM_PD_FWD_EN
  logic                  fwd_valid_r;
  logic [MW-1:0]         fwd_mask_r;
  logic [DATA_WIDTH-1:0] fwd_data_r;

  // Replace the bytes enabled in mask with new data; keep the other bytes from old data.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_d,
    input logic [DATA_WIDTH-1:0] new_d,
    input logic [MW-1:0]         mask
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_d;
    for (int b = 0; b < MW; b++) begin
      if (mask[b]) begin
        res[8*b +: 8] = new_d[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_d[8*b +: 8];
      end
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Write path: posted writes, passed straight through to the RAM
  // ---------------------------------------------------------------------------
  assign wr_ready_o    = wr_ready_r;
  assign wr_fire_s     = wr_valid_i & wr_ready_r;
  assign ram_we_o      = wr_fire_s;
  assign ram_we_mask_o = wr_mask_i;
  assign ram_waddr_o   = wr_addr_i;
  assign ram_data_o    = wr_data_i;

  // ---------------------------------------------------------------------------
  // Read request path
  // ---------------------------------------------------------------------------
  assign ram_raddr_o  = rd_addr_i;
  assign word_match_s = (rd_addr_i[ADDR_WIDTH-1:OFS] == wr_addr_i[ADDR_WIDTH-1:OFS]);

`ifdef GNRL_RAM_PD_FWD_EN
  assign stall_s = 1'b0;
`else
  // The write wins: a read of the word being written this cycle waits one cycle.
  assign stall_s = wr_valid_i & word_match_s;
`endif

  // Credits come only from registered state.
  assign occ_s      = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
  assign rd_ready_s = wr_ready_r & (occ_s < DEPTH_C) & ~stall_s;
  assign rd_ready_o = rd_ready_s;
  assign rd_fire_s  = rd_valid_i & rd_ready_s;

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  assign push_s      = inflight_r;
  assign pop_s       = rsp_valid_r & rsp_ready_i;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = fifo_mem_r[rptr_r];

  // Select the data to capture: RAM read data, merged with forwarded write bytes when enabled.
  always_comb begin
    capture_s = ram_data_i;
`ifdef GNRL_RAM_PD_FWD_EN
    if (fwd_valid_r) begin
      capture_s = merge_bytes(ram_data_i, fwd_data_r, fwd_mask_r);
    end else begin
      capture_s = ram_data_i;
    end
`endif
  end

  // Compute the next FIFO occupancy from push/pop activity.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Control registers: ready flag, in-flight tracking, FIFO pointers and count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ready_r  <= 1'b0;
      inflight_r  <= 1'b0;
      wptr_r      <= {PW{1'b0}};
      rptr_r      <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      rsp_valid_r <= 1'b0;
    end else begin
      wr_ready_r  <= 1'b1;
      inflight_r  <= rd_fire_s;
      count_r     <= count_nxt_s;
      rsp_valid_r <= (count_nxt_s != {CW{1'b0}});
      if (push_s) begin
        wptr_r <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PW'(1);
      end
    end
  end

  // FIFO storage: capture the RAM read data one cycle after the read is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wptr_r] <= capture_s;
      end
    end
  end

`ifdef GNRL_RAM_PD_FWD_EN
  // Forwarding state: remember a write that hit the same word as an accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_valid_r <= 1'b0;
      fwd_mask_r  <= {MW{1'b0}};
      fwd_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      fwd_valid_r <= rd_fire_s & wr_fire_s & word_match_s;
      if (rd_fire_s & wr_fire_s & word_match_s) begin
        fwd_mask_r <= wr_mask_i;
        fwd_data_r <= wr_data_i;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gnrl_ram_pd_initiator.sv
// Testbench for gnrl_ram_pd_initiator. The bench contains a behavioural
// pseudo-dual-port RAM and a reference memory. A monitor pushes the expected
// read data when a read handshake is seen, and compares it when a response is
// consumed.
module tb_gnrl_ram_pd_initiator;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] wr_mask;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          ram_we;
  logic [MW-1:0] ram_we_mask;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;
  int rsp_cnt  = 0;
  logic [DW-1:0] last_rsp = 32'h0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] ram_mem [0:255];
  logic [DW-1:0] ref_mem [0:255];

  always #5 clk = ~clk;

  gnrl_ram_pd_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .wr_mask_i     (wr_mask),
    .rd_valid_i    (rd_valid),
    .rd_ready_o    (rd_ready),
    .rd_addr_i     (rd_addr),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_data_o    (rsp_data),
    .ram_we_o      (ram_we),
    .ram_we_mask_o (ram_we_mask),
    .ram_waddr_o   (ram_waddr),
    .ram_data_o    (ram_wdata),
    .ram_raddr_o   (ram_raddr),
    .ram_data_i    (ram_rdata)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d,
                                          input logic [DW-1:0] new_d,
                                          input logic [MW-1:0] m);
    logic [DW-1:0] r;
    r = old_d;
    for (int b = 0; b < MW; b++) if (m[b]) r[8*b +: 8] = new_d[8*b +: 8];
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural RAM: 1-cycle synchronous read; a same-cycle write is not seen by the read (old data returned).
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_rdata <= 32'h0;
    end else begin
      ram_rdata <= ram_mem[ram_raddr[9:2]];
      if (ram_we) ram_mem[ram_waddr[9:2]] <= merge(ram_mem[ram_waddr[9:2]], ram_wdata, ram_we_mask);
    end
  end

  // Monitor: keep the reference memory, push expected read data, compare responses.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid && wr_ready)
        ref_mem[wr_addr[9:2]] <= merge(ref_mem[wr_addr[9:2]], wr_data, wr_mask);
      if (rd_valid && rd_ready)
        exp_q.push_back((wr_valid && wr_ready && wr_addr[9:2] == rd_addr[9:2]) ?
                        merge(ref_mem[rd_addr[9:2]], wr_data, wr_mask) : ref_mem[rd_addr[9:2]]);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check_eq("rsp_unexpected", 64'd1, 64'd0);
        else check_eq("rsp_data", {32'h0, rsp_data}, {32'h0, exp_q.pop_front()});
        last_rsp <= rsp_data;
        rsp_cnt  <= rsp_cnt + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_mask = m;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int n;
    rd_valid = 1'b1; rd_addr = a;
    n = 0;
    @(negedge clk);
    while (!rd_ready && n < 20) begin
      step(); n++;
      @(negedge clk);
    end
    if (n >= 20) check_eq("read_accept_timeout", 64'd0, 64'd1);
    step();
    rd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
      step(); n++;
    end
    if (n >= 50) check_eq("drain_timeout", 64'd0, 64'd1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt, acc, start;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 1'b1; rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 16'h0; wr_data = 32'h0; wr_mask = 4'h0;
    rd_valid = 1'b1; rd_addr = 16'h0;
    #1;
    // Reset state
    check_eq("rst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check_eq("rst_rd_ready", {63'd0, rd_ready}, 64'd0);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check_eq("rst_ram_we", {63'd0, ram_we}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    step();
    check_eq("wr_ready_after_rst", {63'd0, wr_ready}, 64'd1);

    // Write DEADBEEF @0x10, check pass-through to the RAM port
    wr_valid = 1'b1; wr_addr = 16'h0010; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    @(negedge clk);
    check_eq("ram_we", {63'd0, ram_we}, 64'd1);
    check_eq("ram_waddr", {48'd0, ram_waddr}, 64'h10);
    check_eq("ram_wdata", {32'd0, ram_wdata}, 64'hDEADBEEF);
    check_eq("ram_we_mask", {60'd0, ram_we_mask}, 64'hF);
    step();
    wr_valid = 1'b0;

    // Read 0x10 and check latency: accept at cycle N, response at N+2
    rd_valid = 1'b1; rd_addr = 16'h0010;
    @(negedge clk);
    check_eq("lat_rd_ready", {63'd0, rd_ready}, 64'd1);
    check_eq("ram_raddr", {48'd0, ram_raddr}, 64'h10);
    step();
    rd_valid = 1'b0;
    @(negedge clk);
    check_eq("lat_n1_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    step();
    @(negedge clk);
    check_eq("lat_n2_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    check_eq("lat_n2_rsp_data", {32'd0, rsp_data}, 64'hDEADBEEF);
    step();
    wait_drain();

    // Mask 0 write changes nothing
    do_write(16'h0010, 32'hFFFFFFFF, 4'h0);
    do_read(16'h0010);
    wait_drain();
    check_eq("mask0_data", {32'd0, last_rsp}, 64'hDEADBEEF);

    // Back-to-back 8 reads with distinct data
    for (int i = 0; i < 8; i++) do_write(AW'(i * 4), 32'hA5000000 + DW'(i * 17), 4'hF);
    start = rsp_cnt; low_cnt = 0;
    rd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = AW'(i * 4);
      @(negedge clk);
      if (!rd_ready) low_cnt++;
      step();
    end
    rd_valid = 1'b0;
    check_eq("b2b_rd_ready_low", 64'(low_cnt), 64'd0);
    wait_drain();
    check_eq("b2b_rsp_count", 64'(rsp_cnt - start), 64'd8);

    // Credit limit: rsp_ready low, only 4 reads accepted
    rsp_ready = 1'b0; acc = 0; start = rsp_cnt;
    rd_valid = 1'b1; rd_addr = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rd_ready) begin
        acc++;
        step();
        rd_addr = AW'(acc * 4);
      end else begin
        step();
      end
    end
    @(negedge clk);
    check_eq("credit_accepted", 64'(acc), 64'd4);
    check_eq("credit_rd_ready", {63'd0, rd_ready}, 64'd0);
    check_eq("credit_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    step();
    rsp_ready = 1'b1;
    do_read(rd_addr);
    wait_drain();
    check_eq("credit_rsp_count", 64'(rsp_cnt - start), 64'd5);

    // Same-cycle same-word hazard
    do_write(16'h0020, 32'h11223344, 4'hF);
    wr_valid = 1'b1; wr_addr = 16'h0020; wr_data = 32'hAABBCCDD; wr_mask = 4'b0011;
    rd_valid = 1'b1; rd_addr = 16'h0022;
    @(negedge clk);
`ifdef GNRL_RAM_PD_FWD_EN
    check_eq("hazard_rd_ready", {63'd0, rd_ready}, 64'd1);
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
`else
    check_eq("hazard_stall", {63'd0, rd_ready}, 64'd0);
    step();
    wr_valid = 1'b0;
    @(negedge clk);
    check_eq("hazard_retry", {63'd0, rd_ready}, 64'd1);
    step();
    rd_valid = 1'b0;
`endif
    wait_drain();
    check_eq("hazard_data", {32'd0, last_rsp}, 64'h1122CCDD);

    // Different word, same cycle: no stall
    wr_valid = 1'b1; wr_addr = 16'h0040; wr_data = 32'h0BADF00D; wr_mask = 4'hF;
    rd_valid = 1'b1; rd_addr = 16'h0024;
    @(negedge clk);
    check_eq("nohazard_rd_ready", {63'd0, rd_ready}, 64'd1);
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    wait_drain();

    // Reset with two reads in flight
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 16'h0000;
    step();
    rd_addr = 16'h0004;
    step();
    rd_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 16'h0080;
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("midrst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check_eq("midrst_rd_ready", {63'd0, rd_ready}, 64'd0);
    check_eq("midrst_wr_ready", {63'd0, wr_ready}, 64'd0);
    check_eq("midrst_ram_we", {63'd0, ram_we}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; wr_valid = 1'b0; rsp_ready = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) low_cnt++;
      step();
    end
    check_eq("postrst_stale_rsp", 64'(low_cnt), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
